fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sits directly upstream of the team's dual-port RAM. It converts a valid/ready write stream and a valid/ready read stream into the RAM's write, address and data controls. It adds a 2-entry output buffer, which hides the RAM's 1-cycle read latency and sustains 1 word/cycle in first-word-fall-through mode.

---
 rtl/fifo_ctrl_pkg.sv | 17 +
 rtl/fifo_ctrl_out_buf.sv | 59 +++++
 rtl/fifo_ctrl.sv | 95 +++++++++
 tb/tb_fifo_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and width helpers for the fifo_ctrl RAM front-end.
package fifo_ctrl_pkg;

    localparam int unsigned FIFO_BUF_DEPTH = 2;
    localparam int unsigned BUF_COUNT_BITS = $clog2(FIFO_BUF_DEPTH + 1);

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int unsigned ptr_bits(input int unsigned address_bits);
        return address_bits + 1;
    endfunction

    // Total occupancy reaches 2**address_bits + FIFO_BUF_DEPTH.
    function automatic int unsigned count_bits(input int unsigned address_bits);
        return address_bits + 2;
    endfunction

endpackage

// File: rtl/fifo_ctrl_out_buf.sv
// Two-entry output buffer: absorbs RAM read data and presents a stable head word.
module fifo_ctrl_out_buf
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      capture,
    input  logic [DATA_BITS-1:0]      capture_data,
    input  logic                      ready,
    output logic                      valid,
    output logic [DATA_BITS-1:0]      data,
    output logic [BUF_COUNT_BITS-1:0] level
);

    logic [DATA_BITS-1:0]      head;
    logic [DATA_BITS-1:0]      tail;
    logic [DATA_BITS-1:0]      head_next;
    logic [DATA_BITS-1:0]      tail_next;
    logic [BUF_COUNT_BITS-1:0] level_next;
    logic [BUF_COUNT_BITS-1:0] level_after_pop;
    logic                      pop;

    assign valid = (level != '0);
    assign pop   = valid & ready;
    assign data  = head;

    // Pop shifts tail into head; a capture lands in the first free slot after the pop.
    always_comb begin
        head_next       = head;
        tail_next       = tail;
        level_after_pop = level - BUF_COUNT_BITS'(pop);
        level_next      = level_after_pop + BUF_COUNT_BITS'(capture);
        if (pop) begin
            head_next = tail;
        end
        if (capture) begin
            if (level_after_pop == '0) begin
                head_next = capture_data;
            end else begin
                tail_next = capture_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            level <= level_next;
            head  <= head_next;
            tail  <= tail_next;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving a dual-port RAM, with a 2-entry buffer hiding read latency.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 4,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_BITS-1:0]                in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_BITS-1:0]                out_data,
    output logic [count_bits(ADDRESS_BITS)-1:0] count,
    output logic                                write,
    output logic [ADDRESS_BITS-1:0]             address_in,
    output logic [ADDRESS_BITS-1:0]             address_out,
    output logic [DATA_BITS-1:0]                data_in,
    input  logic [DATA_BITS-1:0]                data_out
);

    localparam int unsigned PW       = ptr_bits(ADDRESS_BITS);
    localparam int unsigned CW       = count_bits(ADDRESS_BITS);
    localparam int unsigned DEPTH    = 1 << ADDRESS_BITS;
    localparam int unsigned OCC_BITS = BUF_COUNT_BITS + 1;

    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [PW-1:0]             wr_ptr_next;
    logic [PW-1:0]             rd_ptr_next;
    logic [PW-1:0]             ram_count;
    logic [PW-1:0]             ram_count_next;
    logic                      inflight;
    logic                      push;
    logic                      pop;
    logic                      issue;
    logic [OCC_BITS-1:0]       occupancy;
    logic [BUF_COUNT_BITS-1:0] buf_level;
    logic [BUF_COUNT_BITS-1:0] buf_level_next;
    logic [CW-1:0]             count_next;

    // Words committed to RAM but not yet issued; the wrap bit separates full from empty.
    assign ram_count = wr_ptr - rd_ptr;

    assign in_ready    = !reset && (ram_count < PW'(DEPTH));
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign write       = push;
    assign address_in  = wr_ptr[ADDRESS_BITS-1:0];
    assign address_out = rd_ptr[ADDRESS_BITS-1:0];
    assign data_in     = in_data;

    // Only issue a read when its data is guaranteed a buffer slot on arrival.
    assign occupancy = OCC_BITS'(buf_level) + OCC_BITS'(inflight);
    assign issue     = (ram_count != '0)
                    && (occupancy < OCC_BITS'(FIFO_BUF_DEPTH) + OCC_BITS'(pop));

    always_comb begin
        wr_ptr_next    = wr_ptr + PW'(push);
        rd_ptr_next    = rd_ptr + PW'(issue);
        ram_count_next = wr_ptr_next - rd_ptr_next;
        buf_level_next = buf_level + BUF_COUNT_BITS'(inflight) - BUF_COUNT_BITS'(pop);
        count_next     = CW'(ram_count_next) + CW'(issue) + CW'(buf_level_next);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            count    <= '0;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            inflight <= issue;
            count    <= count_next;
        end
    end

    fifo_ctrl_out_buf #(
        .DATA_BITS (DATA_BITS)
    ) u_out_buf (
        .clock        (clock),
        .reset        (reset),
        .capture      (inflight),
        .capture_data (data_out),
        .ready        (out_ready),
        .valid        (out_valid),
        .data         (out_data),
        .level        (buf_level)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a behavioural dual-port RAM and a queue-based reference model.
module tb_fifo_ctrl;

    localparam int unsigned AB = 2;
    localparam int unsigned DB = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DB-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DB-1:0] out_data;
    logic [CW-1:0] count;
    logic          write;
    logic [AB-1:0] address_in;
    logic [AB-1:0] address_out;
    logic [DB-1:0] data_in;
    logic [DB-1:0] data_out;

    logic [DB-1:0] ram [D];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DB-1:0] model_q[$];
    int unsigned   wr_total = 0;

    fifo_ctrl #(
        .ADDRESS_BITS (AB),
        .DATA_BITS    (DB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .write       (write),
        .address_in  (address_in),
        .address_out (address_out),
        .data_in     (data_in),
        .data_out    (data_out)
    );

    always #5 clock = ~clock;

    // Dual-port RAM: synchronous write, one-cycle registered read.
    always @(posedge clock) begin
        if (write) ram[address_in] <= data_in;
        data_out <= ram[address_out];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // Called at the negedge: commit this cycle's handshakes to the model, then step to the drive point.
    task automatic advance();
        if (reset) begin
            model_q.delete();
            wr_total = 0;
        end else begin
            if (out_valid && out_ready && model_q.size() > 0) void'(model_q.pop_front());
            if (in_valid && in_ready) begin
                model_q.push_back(in_data);
                wr_total++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            tests_run++;
            if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
            advance();
        end
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++;
        if (count !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
        tests_run++;
        if (write !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b want 0", write); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        advance();
    endtask

    task automatic test_drain(input string name);
        out_ready = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 40 && model_q.size() > 0; c++) begin
            @(negedge clock);
            tests_run++;
            if (count !== CW'(model_q.size())) begin
                tests_failed++; $display("FAIL %s_drain_count: got %0d want %0d", name, count, model_q.size());
            end
            if (out_valid) begin
                tests_run++;
                if (model_q.size() == 0 || out_data !== model_q[0]) begin
                    tests_failed++; $display("FAIL %s_drain_data: got %h want %h", name, out_data, model_q[0]);
                end
            end
            advance();
        end
        tests_run++;
        if (model_q.size() != 0) begin
            tests_failed++; $display("FAIL %s_drain_timeout: %0d words left, want 0", name, model_q.size());
        end
        @(negedge clock);
        tests_run++;
        if (out_valid !== 1'b0 || count !== '0) begin
            tests_failed++; $display("FAIL %s_drain_empty: out_valid=%b count=%0d want 0/0", name, out_valid, count);
        end
        advance();
        out_ready = 1'b0;
    endtask

    task automatic test_latency();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        @(negedge clock);
        tests_run++;
        if (write !== 1'b1 || address_in !== 2'd0) begin
            tests_failed++; $display("FAIL lat_write: write=%b address_in=%0d want 1/0", write, address_in);
        end
        advance();
        in_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (address_out !== 2'd0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL lat_issue: address_out=%0d out_valid=%b want 0/0", address_out, out_valid);
        end
        advance();
        @(negedge clock);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_early: out_valid=%b want 0", out_valid); end
        advance();
        @(negedge clock);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || count !== 4'd1) begin
            tests_failed++;
            $display("FAIL lat_out: out_valid=%b out_data=%h count=%0d want 1/11/1", out_valid, out_data, count);
        end
        advance();
        test_drain("latency");
    endtask

    task automatic test_full();
        int accepted = 0;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = DB'(i + 1);
            @(negedge clock);
            tests_run++;
            if (in_ready !== (i < 6)) begin
                tests_failed++; $display("FAIL full_in_ready[%0d]: got %b want %b", i, in_ready, i < 6);
            end
            if (i == 6) begin
                tests_run++;
                if (write !== 1'b0) begin tests_failed++; $display("FAIL full_write: got %b want 0", write); end
                tests_run++;
                if (count !== 4'd6) begin tests_failed++; $display("FAIL full_count: got %0d want 6", count); end
            end
            if (in_ready) accepted++;
            advance();
        end
        in_valid = 1'b0;
        tests_run++;
        if (accepted != 6) begin tests_failed++; $display("FAIL full_accepted: got %0d want 6", accepted); end
        test_drain("full");
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = DB'(i);
            @(negedge clock);
            tests_run++;
            if (address_in !== AB'(i % 4)) begin
                tests_failed++; $display("FAIL stream_addr_in[%0d]: got %0d want %0d", i, address_in, i % 4);
            end
            if (i >= 1) begin
                tests_run++;
                if (address_out !== AB'((i - 1) % 4)) begin
                    tests_failed++; $display("FAIL stream_addr_out[%0d]: got %0d want %0d", i, address_out, (i - 1) % 4);
                end
            end
            tests_run++;
            if (i >= 3) begin
                if (out_valid !== 1'b1 || out_data !== DB'(i - 3)) begin
                    tests_failed++; $display("FAIL stream_out[%0d]: valid=%b data=%h want 1/%h", i, out_valid, out_data, i - 3);
                end
            end else if (out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL stream_early[%0d]: out_valid=%b want 0", i, out_valid);
            end
            advance();
        end
        test_drain("stream");
    endtask

    task automatic test_backpressure();
        logic          stalled = 1'b0;
        logic [DB-1:0] prev_data = '0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            out_ready = (i % 2) == 1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DB'($urandom);
            @(negedge clock);
            tests_run++;
            if (count !== CW'(model_q.size())) begin
                tests_failed++; $display("FAIL bp_count[%0d]: got %0d want %0d", i, count, model_q.size());
            end
            tests_run++;
            if (write !== (in_valid && in_ready) || data_in !== in_data || address_in !== AB'(wr_total % D)) begin
                tests_failed++;
                $display("FAIL bp_write[%0d]: write=%b data_in=%h address_in=%0d want %b/%h/%0d",
                         i, write, data_in, address_in, in_valid && in_ready, in_data, wr_total % D);
            end
            if (model_q.size() < D) begin
                tests_run++;
                if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_low[%0d]: got %b want 1", i, in_ready); end
            end
            if (model_q.size() == D + 2) begin
                tests_run++;
                if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_full[%0d]: got %b want 0", i, in_ready); end
            end
            if (model_q.size() == 0) begin
                tests_run++;
                if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty[%0d]: out_valid=%b want 0", i, out_valid); end
            end
            if (stalled) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    tests_failed++; $display("FAIL bp_stable[%0d]: valid=%b data=%h want 1/%h", i, out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (model_q.size() == 0 || out_data !== model_q[0]) begin
                    tests_failed++; $display("FAIL bp_data[%0d]: got %h want %h", i, out_data, model_q[0]);
                end
            end
            stalled   = out_valid && !out_ready;
            prev_data = out_data;
            advance();
        end
        test_drain("backpressure");
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = DB'(8'hC0 + i);
            @(negedge clock);
            advance();
        end
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clock);
        tests_run++;
        if (in_ready !== 1'b0 || write !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset_block: in_ready=%b write=%b want 0/0", in_ready, write);
        end
        advance();
        reset = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clock);
        tests_run++;
        if (count !== '0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset_state: count=%0d out_valid=%b want 0/0", count, out_valid);
        end
        tests_run++;
        if (write !== 1'b1 || address_in !== 2'd0) begin
            tests_failed++; $display("FAIL mid_reset_push: write=%b address_in=%0d want 1/0", write, address_in);
        end
        advance();
        in_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clock);
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_stale[%0d]: out_valid=%b want 0", c, out_valid); end
            advance();
        end
        @(negedge clock);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 4'd1) begin
            tests_failed++;
            $display("FAIL mid_reset_out: valid=%b data=%h count=%0d want 1/a5/1", out_valid, out_data, count);
        end
        advance();
        test_drain("mid_reset");
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_latency();
        test_full();
        test_streaming();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
